// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI link: receiver state encoding, byte framing,
// DC encodings and the SSD1306 command bytes the init sequencer emits.
package oled_pkg;

    typedef enum logic [1:0] {
        PRST  = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2
    } rx_state_e;

    localparam int BYTE_BITS = 8;

    localparam logic CMD = 1'b0;
    localparam logic DAT = 1'b1;

    localparam logic [7:0] SSD_DISPLAY_OFF    = 8'hAE;
    localparam logic [7:0] SSD_DISPLAY_ON     = 8'hAF;
    localparam logic [7:0] SSD_SET_CONTRAST   = 8'h81;
    localparam logic [7:0] SSD_CHARGE_PUMP    = 8'h8D;
    localparam logic [7:0] SSD_CHARGE_PUMP_ON = 8'h14;

endpackage

// File: rtl/oled_sync.sv
// Single-bit synchronizer: STAGES flops in series, all preset to RST_VAL on reset.
module oled_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/oled_spi_rx.sv
// Panel-side SPI mode-0 receiver for the OLED link: oversamples the pins, rebuilds
// MSB-first bytes tagged command/data, and keeps per-type byte counters.
module oled_spi_rx
    import oled_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             OLED_SCLK,
    input  logic             OLED_CS,
    input  logic             OLED_DC,
    input  logic             OLED_DIN,
    input  logic             OLED_RST,
    output logic [7:0]       RX_DATA,
    output logic             RX_DC,
    output logic             RX_VALID,
    output logic             FRAME_ERR,
    output logic             PANEL_RST,
    output logic [CNT_W-1:0] CMD_CNT,
    output logic [CNT_W-1:0] DAT_CNT
);

    localparam logic [2:0] LAST_BIT = 3'(BYTE_BITS - 1);

    logic sclk_s, cs_s, dc_s, din_s, orst_s;

    oled_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk_i(CLK), .rst_i(RST), .d_i(OLED_SCLK), .q_o(sclk_s));
    oled_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.clk_i(CLK), .rst_i(RST), .d_i(OLED_CS),   .q_o(cs_s));
    oled_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dc   (.clk_i(CLK), .rst_i(RST), .d_i(OLED_DC),   .q_o(dc_s));
    oled_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din  (.clk_i(CLK), .rst_i(RST), .d_i(OLED_DIN),  .q_o(din_s));
    oled_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_orst (.clk_i(CLK), .rst_i(RST), .d_i(OLED_RST),  .q_o(orst_s));

    rx_state_e        state_q, state_d;
    logic             sclk_prev_q;
    logic [SYNC_STAGES-1:0] flush_q;
    logic             armed_q, armed_d;
    logic [6:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_dc_q, rx_dc_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0] dat_cnt_q, dat_cnt_d;

    logic sclk_rise, byte_done;

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign byte_done = (state_q == SHIFT) && sclk_rise && (bit_cnt_q == LAST_BIT);

    // CS only arms once the flushed synchronizer has shown it high, so a CS still low
    // after reset cannot start a receive mid-byte.
    assign armed_d = armed_q | (flush_q[SYNC_STAGES-1] & cs_s);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            sclk_prev_q <= 1'b0;
            flush_q     <= '0;
            armed_q     <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_dc_q     <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_cnt_q   <= '0;
            dat_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sclk_prev_q <= sclk_s;
            flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            armed_q     <= armed_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_dc_q     <= rx_dc_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            cmd_cnt_q   <= cmd_cnt_d;
            dat_cnt_q   <= dat_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!orst_s) begin
            state_d = PRST;
        end else begin
            case (state_q)
                PRST:    state_d = IDLE;
                IDLE:    if (armed_q && !cs_s) state_d = SHIFT;
                SHIFT:   if (cs_s) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_dc_d     = rx_dc_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        cmd_cnt_d   = cmd_cnt_q;
        dat_cnt_d   = dat_cnt_q;

        if (!orst_s) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            cmd_cnt_d = '0;
            dat_cnt_d = '0;
        end else if (state_q == SHIFT) begin
            if (byte_done) begin
                rx_data_d  = {shift_q, din_s};
                rx_dc_d    = dc_s;
                rx_valid_d = 1'b1;
                shift_d    = '0;
                bit_cnt_d  = '0;
                if (dc_s == CMD) cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
                else             dat_cnt_d = dat_cnt_q + CNT_W'(1);
            end else if (cs_s) begin
                frame_err_d = (bit_cnt_q != 3'd0);
                shift_d     = '0;
                bit_cnt_d   = '0;
            end else if (sclk_rise) begin
                shift_d   = {shift_q[5:0], din_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end else begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end
    end

    assign RX_DATA   = rx_data_q;
    assign RX_DC     = rx_dc_q;
    assign RX_VALID  = rx_valid_q;
    assign FRAME_ERR = frame_err_q;
    assign PANEL_RST = ~orst_s;
    assign CMD_CNT   = cmd_cnt_q;
    assign DAT_CNT   = dat_cnt_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Directed bench for oled_spi_rx: drives the SPI pins like the OLED transmitter and
// checks received bytes, strobes, counters and reset behaviour against hand-computed values.
module tb_oled_spi_rx;
    import oled_pkg::*;

    localparam int CLK_P = 10;
    localparam int HALF  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0, cs = 1'b1, dc = 1'b0, din = 1'b0, orst = 1'b1;

    logic [7:0]  rx_data,  rx_data4;
    logic        rx_dc,    rx_dc4;
    logic        rx_valid, rx_valid4;
    logic        ferr,     ferr4;
    logic        prst,     prst4;
    logic [15:0] cmd_cnt,  dat_cnt;
    logic [3:0]  cmd_cnt4, dat_cnt4;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    logic [8:0] rx_q[$];
    time last_rise_t = 0;
    time valid_t = 0;

    always #(CLK_P/2) clk = ~clk;

    oled_spi_rx #(.SYNC_STAGES(2), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst), .OLED_SCLK(sclk), .OLED_CS(cs), .OLED_DC(dc),
        .OLED_DIN(din), .OLED_RST(orst), .RX_DATA(rx_data), .RX_DC(rx_dc),
        .RX_VALID(rx_valid), .FRAME_ERR(ferr), .PANEL_RST(prst),
        .CMD_CNT(cmd_cnt), .DAT_CNT(dat_cnt)
    );

    oled_spi_rx #(.SYNC_STAGES(2), .CNT_W(4)) dut4 (
        .CLK(clk), .RST(rst), .OLED_SCLK(sclk), .OLED_CS(cs), .OLED_DC(dc),
        .OLED_DIN(din), .OLED_RST(orst), .RX_DATA(rx_data4), .RX_DC(rx_dc4),
        .RX_VALID(rx_valid4), .FRAME_ERR(ferr4), .PANEL_RST(prst4),
        .CMD_CNT(cmd_cnt4), .DAT_CNT(dat_cnt4)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt++;
            rx_q.push_back({rx_dc, rx_data});
            valid_t = $time;
        end
        if (ferr) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_rx(input string tag, input logic dcv, input logic [7:0] b);
        logic [8:0] got;
        got = 9'h1FF;
        if (rx_q.size() > 0) got = rx_q.pop_front();
        else $display("FAIL %s no byte received", tag);
        check(tag, {23'd0, got}, {23'd0, dcv, b});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic dcv);
        logic [7:0] sr;
        sr = b;
        for (int i = 0; i < n; i++) begin
            din  = sr[7];
            dc   = dcv;
            sclk = 1'b0;
            tick(HALF);
            sclk = 1'b1;
            last_rise_t = $time;
            tick(HALF);
            sr = sr << 1;
        end
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dcv);
        send_bits(b, 8, dcv);
    endtask

    task automatic frame_begin();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        tick(4);
        cs = 1'b1;
        tick(10);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  {24'd0, rx_data},  32'd0);
        check({tag, "_dc"},    {31'd0, rx_dc},    32'd0);
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_ferr"},  {31'd0, ferr},     32'd0);
        check({tag, "_prst"},  {31'd0, prst},     32'd0);
        check({tag, "_cmd"},   {16'd0, cmd_cnt},  32'd0);
        check({tag, "_dat"},   {16'd0, dat_cnt},  32'd0);
        check({tag, "_data4"}, {24'd0, rx_data4}, 32'd0);
        check({tag, "_cmd4"},  {28'd0, cmd_cnt4}, 32'd0);
        check({tag, "_dat4"},  {28'd0, dat_cnt4}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        rst = 1'b0;

        // Idle pins after reset: nothing moves.
        tick(50);
        check_all_zero("t1");
        check("t1_valid_cnt", valid_cnt, 0);
        check("t1_ferr_cnt",  ferr_cnt,  0);

        // Single command byte and its latency.
        frame_begin();
        send_byte(SSD_DISPLAY_OFF, CMD);
        frame_end();
        check("t2_valid_cnt", valid_cnt, 1);
        expect_rx("t2_byte", CMD, 8'hAE);
        check("t2_rx_data", {24'd0, rx_data}, 32'h0000_00AE);
        check("t2_cmd_cnt", {16'd0, cmd_cnt}, 1);
        check("t2_latency", 32'((valid_t - last_rise_t) / CLK_P), 3);

        // Back-to-back bytes under one CS; counters are cumulative since reset.
        frame_begin();
        send_byte(SSD_SET_CONTRAST, CMD);
        send_byte(8'h7F, CMD);
        send_byte(8'hFF, DAT);
        send_byte(8'h00, DAT);
        frame_end();
        check("t3_valid_cnt", valid_cnt, 5);
        expect_rx("t3_b0", CMD, 8'h81);
        expect_rx("t3_b1", CMD, 8'h7F);
        expect_rx("t3_b2", DAT, 8'hFF);
        expect_rx("t3_b3", DAT, 8'h00);
        check("t3_cmd_cnt", {16'd0, cmd_cnt}, 3);
        check("t3_dat_cnt", {16'd0, dat_cnt}, 2);

        // CS rises after 5 bits: framing error, then a clean byte.
        frame_begin();
        send_bits(8'hA5, 5, DAT);
        cs = 1'b1;
        tick(10);
        check("t4_ferr_cnt",  ferr_cnt,  1);
        check("t4_valid_cnt", valid_cnt, 5);
        frame_begin();
        send_byte(8'h3C, DAT);
        frame_end();
        check("t4_valid_cnt2", valid_cnt, 6);
        expect_rx("t4_byte", DAT, 8'h3C);
        check("t4_dat_cnt",   {16'd0, dat_cnt}, 3);
        check("t4_ferr_cnt2", ferr_cnt, 1);

        // Panel reset mid-byte clears counters and drops the byte.
        frame_begin();
        send_byte(SSD_DISPLAY_OFF, CMD);
        send_byte(SSD_CHARGE_PUMP, CMD);
        send_byte(SSD_CHARGE_PUMP_ON, CMD);
        send_bits(8'h55, 3, CMD);
        orst = 1'b0;
        send_bits(8'h55 << 3, 5, CMD);
        tick(6);
        check("t5_valid_cnt", valid_cnt, 9);
        expect_rx("t5_b0", CMD, 8'hAE);
        expect_rx("t5_b1", CMD, 8'h8D);
        expect_rx("t5_b2", CMD, 8'h14);
        check("t5_prst",     {31'd0, prst},    1);
        check("t5_prst4",    {31'd0, prst4},   1);
        check("t5_cmd_cnt",  {16'd0, cmd_cnt}, 0);
        check("t5_dat_cnt",  {16'd0, dat_cnt}, 0);
        check("t5_cmd_cnt4", {28'd0, cmd_cnt4}, 0);
        cs = 1'b1;
        tick(6);
        orst = 1'b1;
        tick(6);
        check("t5_prst_rel", {31'd0, prst}, 0);
        frame_begin();
        send_byte(SSD_DISPLAY_ON, CMD);
        frame_end();
        check("t5_valid_cnt2", valid_cnt, 10);
        expect_rx("t5_on", CMD, 8'hAF);
        check("t5_cmd_cnt2", {16'd0, cmd_cnt}, 1);
        check("t5_dat_cnt2", {16'd0, dat_cnt}, 0);

        // 17 data bytes: the 4-bit counter wraps to 1, the 16-bit one reads 17.
        frame_begin();
        for (int i = 0; i < 17; i++) send_byte(8'(8'h10 + i), DAT);
        frame_end();
        check("t6_valid_cnt", valid_cnt, 27);
        for (int i = 0; i < 17; i++) expect_rx("t6_byte", DAT, 8'(8'h10 + i));
        check("t6_dat_cnt",   {16'd0, dat_cnt},  17);
        check("t6_dat_cnt4",  {28'd0, dat_cnt4}, 1);
        check("t6_cmd_cnt4",  {28'd0, cmd_cnt4}, 1);
        check("t6_rx_data4",  {24'd0, rx_data4}, 32'h0000_0020);
        check("t6_rx_dc",     {31'd0, rx_dc},    1);

        // Async reset mid-byte: outputs clear before the next clock edge.
        frame_begin();
        send_bits(8'hC3, 4, DAT);
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
        tick(2);
        rst = 1'b0;
        tick(10);
        check("t6_no_valid", valid_cnt, 27);
        check("t6_no_ferr",  ferr_cnt,  1);
        cs = 1'b1;
        tick(10);
        frame_begin();
        send_byte(SSD_DISPLAY_OFF, CMD);
        frame_end();
        expect_rx("t6_restart", CMD, 8'hAE);
        check("t6_cmd_restart", {16'd0, cmd_cnt}, 1);
        check("t6_dat_restart", {16'd0, dat_cnt}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
